pattern_generator: RTL

- Parametrised successor to the fixed tiled colour source.
- Produces RGB for the VGA pixel stream from the timing controller's Display, Column and Row.
- Configurable tile grid, colour width, run-time pattern mode and frame-based animated scrolling.
- Two-stage registered pipeline; sits between the VGA timing controller and the DAC/output pins.

---
 rtl/pattern_generator.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pattern_generator.sv
// Purpose : tiled / scrolling / checker / gradient RGB source for the VGA pixel stream.
// Latency : inputs sampled on rising edge N appear on red/green/blue/pix_valid/frame_start after edge N+2.
// Backpr. : none; the pipeline advances every pxclk cycle and never stalls.
//
// Ports:
//   pxclk, rst_n          pixel clock (rising edge), asynchronous active-low reset
//   Display, Column, Row  active-video flag and pixel coordinates from the timing controller
//   mode                  pattern select (0 grid, 1 scroll bars, 2 checker, 3 gradient),
//                         taken into a shadow register at frame start only
//   red, green, blue      COLOR_W-bit colour channels, zero while blanked
//   pix_valid             Display delayed to line up with the colour outputs
//   frame_start           one-cycle pulse aligned with the colour of pixel (0,0)
// Build option: define GRID_OVERLAY_EN to force 1-pixel white tile borders in modes 0-2.
module pattern_generator #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int TILES_X         = 4,
  parameter int TILES_Y         = 3,
  parameter int COLOR_W         = 8,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic               pxclk,
  input  logic               rst_n,
  input  logic               Display,
  input  logic [9:0]         Column,
  input  logic [9:0]         Row,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               pix_valid,
  output logic               frame_start
);

  localparam int TW = H_ACTIVE / TILES_X;
  localparam int TH = V_ACTIVE / TILES_Y;

  localparam logic [9:0] TW_LAST  = 10'(TW - 1);
  localparam logic [9:0] TH_LAST  = 10'(TH - 1);
  localparam logic [3:0] TX_LAST  = 4'(TILES_X - 1);
  localparam logic [3:0] TY_LAST  = 4'(TILES_Y - 1);
  localparam logic [7:0] FPS_LAST = 8'(FRAMES_PER_STEP - 1);

  // ---------------------------------------------------------------------------
  // Stage A: tile tracking, frame-start bookkeeping, coordinate capture
  // ---------------------------------------------------------------------------
  logic [9:0] in_x, in_y;        // position inside the current tile
  logic [3:0] tile_x, tile_y;    // tile of the pixel sampled last edge
  logic       a_vld, a_fs;
  logic [7:0] a_col_hi;          // Column[9:2] for the gradient
  logic [7:0] a_row_hi;          // Row[8:1] for the gradient
  logic [1:0] mode_q;
  logic [7:0] frame_cnt;
  logic [2:0] scroll;            // running step count
  logic [2:0] scroll_q;          // step value shown in the current frame

  logic frame_hit;
  assign frame_hit = Display && (Column == 10'd0) && (Row == 10'd0);

  always_ff @(posedge pxclk or negedge rst_n) begin
    if (!rst_n) begin
      in_x      <= '0;
      in_y      <= '0;
      tile_x    <= '0;
      tile_y    <= '0;
      a_vld     <= 1'b0;
      a_fs      <= 1'b0;
      a_col_hi  <= '0;
      a_row_hi  <= '0;
      mode_q    <= '0;
      frame_cnt <= '0;
      scroll    <= '0;
      scroll_q  <= '0;
    end else begin
      a_vld    <= Display;
      a_fs     <= frame_hit;
      a_col_hi <= Column[9:2];
      a_row_hi <= Row[8:1];

      if (Display) begin
        if (Column == 10'd0) begin
          // Column 0 opens a line: restart X, and step Y once for the line.
          in_x   <= '0;
          tile_x <= '0;
          if (Row == 10'd0) begin
            in_y   <= '0;
            tile_y <= '0;
          end else if (in_y == TH_LAST && tile_y != TY_LAST) begin
            in_y   <= '0;
            tile_y <= tile_y + 4'd1;
          end else if (in_y != 10'h3FF) begin
            // Remainder lines stay in the last tile; saturate so tiles never wrap.
            in_y <= in_y + 10'd1;
          end
        end else if (in_x == TW_LAST && tile_x != TX_LAST) begin
          in_x   <= '0;
          tile_x <= tile_x + 4'd1;
        end else if (in_x != 10'h3FF) begin
          in_x <= in_x + 10'd1;
        end
      end

      if (frame_hit) begin
        mode_q <= mode;
        // A step taken at this frame start becomes visible from the next frame,
        // so a frame always shows the step count accumulated before it began.
        scroll_q <= scroll;
        if (frame_cnt == FPS_LAST) begin
          frame_cnt <= '0;
          scroll    <= scroll + 3'd1;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: palette index and gradient values
  // ---------------------------------------------------------------------------
  logic [2:0]         idx_c;
  logic [COLOR_W-1:0] grad_r, grad_g;

  always_comb begin
    idx_c = 3'd7;
    case (mode_q)
      2'd0:    idx_c = 3'(32'(tile_y) * TILES_X + 32'(tile_x));
      2'd1:    idx_c = tile_x[2:0] + scroll_q;
      2'd2:    idx_c = (tile_x[0] ^ tile_y[0]) ? 3'd6 : 3'd7;
      default: idx_c = 3'd7;
    endcase
  end

  // Gradient bytes are MSB-aligned onto the channel width.
  generate
    if (COLOR_W == 8) begin : g_grad_eq
      assign grad_r = a_col_hi;
      assign grad_g = a_row_hi;
    end else if (COLOR_W > 8) begin : g_grad_wide
      assign grad_r = {a_col_hi, {(COLOR_W-8){1'b0}}};
      assign grad_g = {a_row_hi, {(COLOR_W-8){1'b0}}};
    end else begin : g_grad_narrow
      assign grad_r = a_col_hi[7 -: COLOR_W];
      assign grad_g = a_row_hi[7 -: COLOR_W];
    end
  endgenerate

  logic               b_vld, b_fs, b_grad;
  logic [2:0]         b_idx;
  logic [COLOR_W-1:0] b_rg, b_gg;
`ifdef GRID_OVERLAY_EN
  logic               b_border;
`endif

  always_ff @(posedge pxclk or negedge rst_n) begin
    if (!rst_n) begin
      b_vld    <= 1'b0;
      b_fs     <= 1'b0;
      b_grad   <= 1'b0;
      b_idx    <= '0;
      b_rg     <= '0;
      b_gg     <= '0;
`ifdef GRID_OVERLAY_EN
      b_border <= 1'b0;
`endif
    end else begin
      b_vld    <= a_vld;
      b_fs     <= a_fs;
      b_grad   <= (mode_q == 2'd3);
      b_idx    <= idx_c;
      b_rg     <= grad_r;
      b_gg     <= grad_g;
`ifdef GRID_OVERLAY_EN
      b_border <= (mode_q != 2'd3) && ((in_x == 10'd0) || (in_y == 10'd0));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: palette lookup, blanking, registered outputs
  // ---------------------------------------------------------------------------
  logic [2:0] rgb_bits;    // {r,g,b} full-scale / off for the palette colour

  always_comb begin
    rgb_bits = 3'b000;
    case (b_idx)
      3'd0: rgb_bits = 3'b100;   // red
      3'd1: rgb_bits = 3'b010;   // green
      3'd2: rgb_bits = 3'b001;   // blue
      3'd3: rgb_bits = 3'b110;   // yellow
      3'd4: rgb_bits = 3'b011;   // cyan
      3'd5: rgb_bits = 3'b101;   // magenta
      3'd6: rgb_bits = 3'b111;   // white
      default: rgb_bits = 3'b000; // black
    endcase
`ifdef GRID_OVERLAY_EN
    if (b_border) rgb_bits = 3'b111;
`endif
  end

  always_ff @(posedge pxclk or negedge rst_n) begin
    if (!rst_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= b_vld;
      frame_start <= b_fs;
      if (!b_vld) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else if (b_grad) begin
        red   <= b_rg;
        green <= b_gg;
        blue  <= '0;
      end else begin
        red   <= {COLOR_W{rgb_bits[2]}};
        green <= {COLOR_W{rgb_bits[1]}};
        blue  <= {COLOR_W{rgb_bits[0]}};
      end
    end
  end

endmodule
